// File: rtl/core_pkg.sv
// core_pkg: shared constants and fetch FSM state type for the 5-stage core
// Contents: XLEN, NOP_INSTR (addi x0,x0,0 bubble), fetch_state_t {REQ, HOLD, DROP}.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: pipeline stage register with flush > stall > load > bubble priority
// Ports: clk, rst (async, active-high); flush_i, stall_i, load_i controls;
// instr_i, pc_i payload in; valid_o, instr_o, pc_o, pc_plus4_o registered out.
// A bubble clears valid and inserts BUBBLE_INSTR but keeps pc/pc_plus4.
module fd_pipe_reg import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic            take, bubble;
  assign take   = !flush_i && !stall_i && load_i;
  assign bubble = flush_i || (!stall_i && !load_i);
  always_comb begin
    valid_d = take ? 1'b1 : bubble ? 1'b0 : valid_q;
    instr_d = take ? instr_i : bubble ? BUBBLE_INSTR : instr_q;
    pc_d    = take ? pc_i : pc_q;
    pc4_d   = take ? pc_i + 32'd4 : pc4_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= BUBBLE_INSTR;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end
  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem req/ack handshake and F/D register
// Ports: clk, rst (async, active-high); hazard controls f_in_stall_en,
// d_in_stall_en, d_in_flush_en; redirect e_in_branch_en/e_in_branch_target;
// imem_out_req/imem_out_addr, imem_in_ack/imem_in_rdata; F/D outputs
// f_out_instr, f_out_pc, f_out_pc_plus4, f_out_valid.
// Optional: FETCH_PERF_CNT_EN adds f_out_stall_cnt and f_out_redirect_cnt.
module fetch_unit import core_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_in_stall_en,
  input  logic        d_in_stall_en,
  input  logic        d_in_flush_en,
  input  logic        e_in_branch_en,
  input  logic [31:0] e_in_branch_target,
  output logic        imem_out_req,
  output logic [31:0] imem_out_addr,
  input  logic        imem_in_ack,
  input  logic [31:0] imem_in_rdata,
  output logic [31:0] f_out_instr,
  output logic [31:0] f_out_pc,
  output logic [31:0] f_out_pc_plus4,
  output logic        f_out_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] f_out_stall_cnt,
  output logic [31:0] f_out_redirect_cnt
`endif
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, pend_q, pend_d, skid_q, skid_d, fd_data;
  logic         fd_load;
  // In HOLD the PC is frozen, so pc_q is also the address of the skid entry.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    skid_d  = skid_q;
    fd_load = 1'b0;
    fd_data = imem_in_rdata;
    case (state_q)
      REQ: begin
        if (imem_in_ack) begin
          if (e_in_branch_en) pc_d = e_in_branch_target;
          else if (f_in_stall_en) begin
            skid_d  = imem_in_rdata;
            state_d = HOLD;
          end else begin
            fd_load = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end else if (e_in_branch_en) begin
          pend_d  = e_in_branch_target;
          state_d = DROP;
        end
      end
      HOLD: begin
        fd_data = skid_q;
        if (e_in_branch_en) begin
          pc_d    = e_in_branch_target;
          state_d = REQ;
        end else if (!f_in_stall_en) begin
          fd_load = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      DROP: begin
        // The in-flight request must complete at its old address; a branch
        // arriving together with that ack is the newest redirect and wins.
        if (imem_in_ack) begin
          pc_d    = e_in_branch_en ? e_in_branch_target : pend_q;
          state_d = REQ;
        end else if (e_in_branch_en) pend_d = e_in_branch_target;
      end
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      skid_q  <= skid_d;
    end
  end
  assign imem_out_req  = state_q != HOLD;
  assign imem_out_addr = pc_q;
  fd_pipe_reg #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(NOP_INSTR)) u_fd (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (d_in_flush_en || e_in_branch_en),
    .stall_i   (d_in_stall_en),
    .load_i    (fd_load),
    .instr_i   (fd_data),
    .pc_i      (pc_q),
    .valid_o   (f_out_valid),
    .instr_o   (f_out_instr),
    .pc_o      (f_out_pc),
    .pc_plus4_o(f_out_pc_plus4)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, redirect_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_q + {31'b0, f_in_stall_en};
      redirect_cnt_q <= redirect_cnt_q + {31'b0, e_in_branch_en};
    end
  end
  assign f_out_stall_cnt    = stall_cnt_q;
  assign f_out_redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized check of fetch_unit against a queue-based model
module tb_fetch_unit;
  import core_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 1'b0, rst;
  logic f_stall, d_stall, d_flush, br, ack;
  logic [31:0] tgt, rdata;
  logic req, fv;
  logic [31:0] addr, fi, fpc, fpc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, redir_cnt, m_stall_cnt, m_redir_cnt;
`endif
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .f_in_stall_en(f_stall), .d_in_stall_en(d_stall), .d_in_flush_en(d_flush),
    .e_in_branch_en(br), .e_in_branch_target(tgt),
    .imem_out_req(req), .imem_out_addr(addr),
    .imem_in_ack(ack), .imem_in_rdata(rdata),
    .f_out_instr(fi), .f_out_pc(fpc), .f_out_pc_plus4(fpc4), .f_out_valid(fv)
`ifdef FETCH_PERF_CNT_EN
    , .f_out_stall_cnt(stall_cnt), .f_out_redirect_cnt(redir_cnt)
`endif
  );
  int n_checks = 0, n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: current fetch PC, a 0/1-entry buffer of {instr,pc}, an optional
  // pending redirect waiting for an in-flight ack, and the F/D contents.
  logic [31:0] m_pc, m_pend, m_instr, m_fpc, m_fpc4;
  logic [63:0] m_skid[$];
  bit m_drop, m_valid;
  task automatic mreset();
    m_pc = RPC; m_skid.delete(); m_drop = 0; m_pend = 0;
    m_valid = 0; m_instr = NOP_INSTR; m_fpc = RPC; m_fpc4 = RPC + 4;
`ifdef FETCH_PERF_CNT_EN
    m_stall_cnt = 0; m_redir_cnt = 0;
`endif
  endtask
  task automatic mstep();
    bit del, busy;
    logic [31:0] di, dp;
    logic [63:0] s;
    del = 0; di = 0; dp = 0;
    busy = m_skid.size() != 0;
    if (!busy && ack) begin
      if (m_drop) begin m_pc = br ? tgt : m_pend; m_drop = 0; end
      else if (br) m_pc = tgt;
      else if (f_stall) m_skid.push_back({rdata, m_pc});
      else begin del = 1; di = rdata; dp = m_pc; m_pc = m_pc + 4; end
    end else if (!busy && br) begin
      m_drop = 1; m_pend = tgt;
    end else if (busy) begin
      if (br) begin m_skid.delete(); m_pc = tgt; end
      else if (!f_stall) begin
        s = m_skid.pop_front(); del = 1; di = s[63:32]; dp = s[31:0]; m_pc = m_pc + 4;
      end
    end
    if (d_flush || br) begin m_valid = 0; m_instr = NOP_INSTR; end
    else if (d_stall) ;
    else if (del) begin m_valid = 1; m_instr = di; m_fpc = dp; m_fpc4 = dp + 4; end
    else begin m_valid = 0; m_instr = NOP_INSTR; end
`ifdef FETCH_PERF_CNT_EN
    m_stall_cnt += 32'(f_stall);
    m_redir_cnt += 32'(br);
`endif
  endtask
  task automatic compare_all();
    chk("req", 32'(req), 32'(m_skid.size() == 0));
    chk("addr", addr, m_pc);
    chk("valid", 32'(fv), 32'(m_valid));
    chk("instr", fi, m_instr);
    chk("fd_pc", fpc, m_fpc);
    chk("fd_pc4", fpc4, m_fpc4);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    chk("redir_cnt", redir_cnt, m_redir_cnt);
`endif
  endtask
  task automatic tick();
    bit w;
    logic [31:0] a;
    w = req && !ack && !rst;
    a = addr;
    @(posedge clk); #1;
    if (rst) mreset(); else mstep();
    if (!rst && w) chk("addr_stable", addr, a);
    compare_all();
  endtask
  int mem_wait = 0;
  bit mem_new = 1;
  task automatic set_mem();
    if (req) begin
      if (mem_new) begin
        mem_wait = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
        mem_new = 0;
      end
      ack = mem_wait == 0;
      if (ack) begin rdata = $urandom; mem_new = 1; end
      else mem_wait--;
    end else begin
      ack = $urandom % 8 == 0;
      rdata = $urandom;
      mem_new = 1;
    end
  endtask
  task automatic do_reset();
    #2 rst = 1; ack = 0; br = 0; f_stall = 0; d_stall = 0; d_flush = 0;
    #1 mreset();
    compare_all();
    tick(); tick();
    rst = 0; mem_new = 1;
  endtask
  initial begin
    rst = 1; f_stall = 0; d_stall = 0; d_flush = 0; br = 0; tgt = 0; ack = 0; rdata = 0;
    mreset();
    tick(); tick();
    chk("rst_valid", 32'(fv), 32'd0);
    chk("rst_instr", fi, 32'h0000_0013);
    chk("rst_pc", fpc, 32'h0);
    chk("rst_pc4", fpc4, 32'h4);
    rst = 0;
    chk("first_addr", addr, 32'h0);
    ack = 1; rdata = addr; tick();
    chk("fd0_valid", 32'(fv), 32'd1);
    chk("fd0_pc", fpc, 32'h0);
    chk("addr4", addr, 32'h4);
    rdata = addr; tick();
    chk("addr8", addr, 32'h8);
    chk("fd1_pc", fpc, 32'h4);
    rdata = addr; f_stall = 1; d_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ack = 0;
      chk("stall_req", 32'(req), 32'd0);
      chk("stall_pc", fpc, 32'h4);
    end
    f_stall = 0; d_stall = 0; tick();
    chk("skid_pc", fpc, 32'h8);
    chk("skid_instr", fi, 32'h8);
    chk("addr12", addr, 32'hC);
    ack = 1; rdata = addr; br = 1; tgt = 32'h100; tick();
    chk("br_addr", addr, 32'h100);
    chk("br_bubble", 32'(fv), 32'd0);
    chk("br_nop", fi, 32'h0000_0013);
    chk("br_pc_kept", fpc, 32'h8);
    ack = 0; tgt = 32'h200; tick();
    br = 0; tick(); tick();
    chk("drop_addr", addr, 32'h100);
    ack = 1; rdata = 32'hDEAD_BEEF; tick();
    chk("drop_target", addr, 32'h200);
    chk("drop_discard", 32'(fv), 32'd0);
    rdata = addr; f_stall = 1; d_stall = 1; br = 1; tgt = 32'h300; tick();
    chk("brstall_req", 32'(req), 32'd1);
    chk("brstall_addr", addr, 32'h300);
    br = 0; rdata = addr; tick();
    chk("hold_req", 32'(req), 32'd0);
    ack = 0; br = 1; tgt = 32'hFFFF_FFFC; tick();
    chk("hold_br_addr", addr, 32'hFFFF_FFFC);
    chk("hold_br_bubble", 32'(fv), 32'd0);
    br = 0; f_stall = 0; d_stall = 0; ack = 1; rdata = 32'h1234; tick();
    chk("wrap_pc", fpc, 32'hFFFF_FFFC);
    chk("wrap_pc4", fpc4, 32'h0);
    chk("wrap_addr", addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", stall_cnt, 32'd6);
    chk("perf_redir", redir_cnt, 32'd4);
`endif
    ack = 0; mem_new = 1;
    for (int i = 0; i < 4000; i++) begin
      f_stall = $urandom % 5 == 0;
      d_stall = ($urandom % 10 == 0) ? 1'($urandom % 2) : f_stall;
      d_flush = $urandom % 20 == 0;
      br = $urandom % 10 == 0;
      tgt = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      set_mem();
      tick();
      if ($urandom % 400 == 0) do_reset();
    end
`ifdef FETCH_PERF_CNT_EN
    do_reset();
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_redir", redir_cnt, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
